// File: rtl/sdram_pkg.sv
// sdram_pkg: types and widths shared between the refresh scheduler and the SDRAM controller.
package sdram_pkg;

  localparam int DEBT_W = 4;
  localparam int RANK_W = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_RELEASE = 2'd2
  } ref_state_e;

endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchroniser bringing a level signal into the ECLK domain.
module sync2 (
  input  logic ECLK,
  input  logic RESET_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  // NOTE: flops take non-blocking assignments so every stage samples the pre-edge value of the one before it.
  always_ff @(posedge ECLK or negedge RESET_n) begin
    if (!RESET_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/sdram_refresh_sched.sv
// sdram_refresh_sched: credit/debt refresh scheduler driving a 4-phase req/ack handshake.
// Define REFRESH_STAGGER_EN to refresh one rank per handshake, round-robin over RANKS.
module sdram_refresh_sched
  import sdram_pkg::*;
#(
  parameter int INTERVAL = 4,
  parameter int MAX_DEBT = 8,
  parameter int URGENT   = 6,
  parameter int RANKS    = 2
) (
  input  logic       ECLK,
  input  logic       RESET_n,
  input  logic       enable,
  input  logic       idle_hint,
  input  logic       ref_ack,
  output logic       ref_req,
  output logic       ref_all,
  output logic [1:0] ref_rank,
  output logic       ref_urgent,
  output logic [3:0] debt,
  output logic       overflow
);

  localparam int CNT_W = $clog2(INTERVAL);
  localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'(INTERVAL - 1);
  localparam logic [DEBT_W-1:0] DEBT_MAX   = DEBT_W'(MAX_DEBT);
  localparam logic [DEBT_W-1:0] DEBT_URG   = DEBT_W'(URGENT);

  localparam logic [1:0] IDLE    = 2'(ST_IDLE);
  localparam logic [1:0] REQ     = 2'(ST_REQ);
  localparam logic [1:0] RELEASE = 2'(ST_RELEASE);

  if (INTERVAL < 2 || MAX_DEBT < 2 || MAX_DEBT > 15 || URGENT < 1 || URGENT > MAX_DEBT ||
      RANKS < 1 || RANKS > 4) begin : g_bad_params
    $error("sdram_refresh_sched: parameter out of range");
  end

  logic idle_s, ack_s;

  sync2 u_idle_sync (.ECLK(ECLK), .RESET_n(RESET_n), .d(idle_hint), .q(idle_s));
  sync2 u_ack_sync  (.ECLK(ECLK), .RESET_n(RESET_n), .d(ref_ack),   .q(ack_s));

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DEBT_W-1:0] debt_q, debt_d;
  logic              overflow_q, overflow_d;
  logic              ref_req_q, ref_req_d;
  logic              credit, done, issue, urgent;

  assign urgent = (debt_q >= DEBT_URG);

  // NOTE: every *_d gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    credit = enable && (cnt_q == '0);
    done   = (state_q == RELEASE) && !ack_s;
    issue  = enable && (debt_q != '0) && (idle_s || urgent);

    cnt_d = cnt_q - CNT_W'(1);
    if (!enable || credit) cnt_d = CNT_RELOAD;

    state_d = state_q;
    case (state_q)
      IDLE:    if (issue) state_d = REQ;
      REQ:     if (ack_s) state_d = RELEASE;
      RELEASE: if (!ack_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Debt only clears while disabled once no handshake is left in flight.
    debt_d     = debt_q;
    overflow_d = overflow_q;
    if (!enable && (state_q == IDLE || done)) begin
      debt_d = '0;
    end else if (credit && !done) begin
      if (debt_q == DEBT_MAX) overflow_d = 1'b1;
      else                    debt_d     = debt_q + DEBT_W'(1);
    end else if (done && !credit) begin
      debt_d = debt_q - DEBT_W'(1);
    end

    ref_req_d = (state_d == REQ);
  end

  always_ff @(posedge ECLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q    <= IDLE;
      cnt_q      <= CNT_RELOAD;
      debt_q     <= '0;
      overflow_q <= 1'b0;
      ref_req_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      debt_q     <= debt_d;
      overflow_q <= overflow_d;
      ref_req_q  <= ref_req_d;
    end
  end

  assign ref_req    = ref_req_q;
  assign ref_urgent = urgent;
  assign debt       = debt_q;
  assign overflow   = overflow_q;

`ifdef REFRESH_STAGGER_EN
  localparam logic [RANK_W-1:0] RANK_LAST = RANK_W'(RANKS - 1);

  logic [RANK_W-1:0] rank_q, rank_d;

  // The rank only moves on handshake completion, so it is stable for the whole REQ/RELEASE span.
  always_comb begin
    rank_d = rank_q;
    if (done) rank_d = (rank_q == RANK_LAST) ? '0 : rank_q + RANK_W'(1);
  end

  always_ff @(posedge ECLK or negedge RESET_n) begin
    if (!RESET_n) rank_q <= '0;
    else          rank_q <= rank_d;
  end

  assign ref_all  = 1'b0;
  assign ref_rank = rank_q;
`else
  assign ref_all  = 1'b1;
  assign ref_rank = '0;
`endif

endmodule

// File: tb/tb_sdram_refresh_sched.sv
// tb_sdram_refresh_sched: directed scenarios plus a randomized run against a behavioural model.
module tb_sdram_refresh_sched;

  localparam int INTERVAL = 4;
  localparam int MAX_DEBT = 8;
  localparam int URGENT   = 6;
  localparam int RANKS    = 3;
`ifdef REFRESH_STAGGER_EN
  localparam bit STAGGER = 1'b1;
`else
  localparam bit STAGGER = 1'b0;
`endif

  logic       ECLK, RESET_n, enable, idle_hint, ref_ack;
  logic       ref_req, ref_all, ref_urgent, overflow;
  logic [1:0] ref_rank;
  logic [3:0] debt;

  int checks = 0;
  int errors = 0;

  bit resp_hold = 1'b0;
  bit resp_rand = 1'b0;
  int resp_dly  = 0;

  sdram_refresh_sched #(
    .INTERVAL(INTERVAL), .MAX_DEBT(MAX_DEBT), .URGENT(URGENT), .RANKS(RANKS)
  ) dut (
    .ECLK(ECLK), .RESET_n(RESET_n), .enable(enable), .idle_hint(idle_hint),
    .ref_ack(ref_ack), .ref_req(ref_req), .ref_all(ref_all), .ref_rank(ref_rank),
    .ref_urgent(ref_urgent), .debt(debt), .overflow(overflow)
  );

  initial begin
    ECLK = 1'b0;
    forever #5 ECLK = ~ECLK;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Controller side: ack follows req (optionally after a random delay), drops once req is seen low.
  initial begin
    ref_ack = 1'b0;
    forever begin
      @(negedge ECLK);
      if (!RESET_n || resp_hold) begin
        ref_ack  = 1'b0;
        resp_dly = 0;
      end else if (ref_req && !ref_ack) begin
        if (resp_dly == 0) ref_ack = 1'b1;
        else               resp_dly--;
      end else if (!ref_req && ref_ack) begin
        ref_ack  = 1'b0;
        resp_dly = resp_rand ? int'($urandom_range(0, 3)) : 0;
      end
    end
  end

  // Reference model: credits from an edge count, debt as saturating arithmetic,
  // handshake as an abstract phase (0 waiting, 1 requesting, 2 releasing).
  int m_ticks, m_debt, m_phase;
  bit m_ovf, m_req, m_idle1, m_idle_s, m_ack1, m_ack_s;

  always @(posedge ECLK or negedge RESET_n) begin
    bit credit, fin, go;
    int nd, nph;
    if (!RESET_n) begin
      m_ticks <= 0; m_debt <= 0; m_phase <= 0; m_ovf <= 1'b0; m_req <= 1'b0;
      m_idle1 <= 1'b0; m_idle_s <= 1'b0; m_ack1 <= 1'b0; m_ack_s <= 1'b0;
    end else begin
      credit = enable && ((m_ticks + 1) % INTERVAL == 0);
      fin    = (m_phase == 2) && !m_ack_s;
      go     = (m_phase == 0) && enable && (m_debt > 0) && (m_idle_s || m_debt >= URGENT);
      nph    = m_phase;
      if (go) nph = 1;
      else if (m_phase == 1 && m_ack_s) nph = 2;
      else if (fin) nph = 0;
      if (!enable && (m_phase == 0 || fin)) begin
        m_debt <= 0;
      end else begin
        nd = m_debt + int'(credit) - int'(fin);
        if (nd > MAX_DEBT) begin
          nd = MAX_DEBT;
          m_ovf <= 1'b1;
        end
        m_debt <= nd;
      end
      m_ticks  <= enable ? m_ticks + 1 : 0;
      m_phase  <= nph;
      m_req    <= (nph == 1);
      m_idle1  <= idle_hint;
      m_idle_s <= m_idle1;
      m_ack1   <= ref_ack;
      m_ack_s  <= m_ack1;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge ECLK);
  endtask

  task automatic do_reset();
    RESET_n   = 1'b0;
    enable    = 1'b0;
    idle_hint = 1'b0;
    resp_hold = 1'b0;
    resp_rand = 1'b0;
    tick(2);
    RESET_n = 1'b1;
    tick(1);
  endtask

  task automatic wait_rise(input int budget, output int waited, output bit ok);
    bit prev;
    prev   = ref_req;
    ok     = 1'b0;
    waited = budget;
    for (int i = 1; i <= budget; i++) begin
      tick(1);
      if (ref_req && !prev) begin
        waited = i;
        ok     = 1'b1;
        break;
      end
      prev = ref_req;
    end
  endtask

  task automatic test_reset();
    RESET_n = 1'b0; enable = 1'b0; idle_hint = 1'b0;
    tick(2);
    checks++; if (ref_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b want 0", ref_req); end
    checks++; if (ref_all !== !STAGGER) begin errors++; $display("FAIL reset_all: got %b want %b", ref_all, !STAGGER); end
    checks++; if (ref_rank !== 2'd0) begin errors++; $display("FAIL reset_rank: got %0d want 0", ref_rank); end
    checks++; if (ref_urgent !== 1'b0) begin errors++; $display("FAIL reset_urgent: got %b want 0", ref_urgent); end
    checks++; if (debt !== 4'd0) begin errors++; $display("FAIL reset_debt: got %0d want 0", debt); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    RESET_n = 1'b1;
    tick(1);
  endtask

  task automatic test_first_credit();
    int w, last;
    bit ok;
    do_reset();
    idle_hint = 1'b1;
    tick(3);
    enable = 1'b1;
    tick(3);
    checks++; if (debt !== 4'd0) begin errors++; $display("FAIL credit_e3: debt %0d want 0", debt); end
    tick(1);
    checks++; if (debt !== 4'd1) begin errors++; $display("FAIL credit_e4: debt %0d want 1", debt); end
    checks++; if (ref_req !== 1'b0) begin errors++; $display("FAIL req_e4: got %b want 0", ref_req); end
    tick(1);
    checks++; if (ref_req !== 1'b1) begin errors++; $display("FAIL req_e5: got %b want 1", ref_req); end
    tick(3);
    checks++; if (ref_req !== 1'b0) begin errors++; $display("FAIL req_fall_e8: got %b want 0", ref_req); end
    tick(2);
    checks++; if (debt !== 4'd2) begin errors++; $display("FAIL debt_e10: got %0d want 2", debt); end
    tick(1);
    checks++; if (debt !== 4'd1) begin errors++; $display("FAIL debt_done_e11: got %0d want 1", debt); end
    tick(1);
    checks++; if (ref_req !== 1'b1) begin errors++; $display("FAIL b2b_e12: got %b want 1", ref_req); end
    last = 0;
    for (int k = 0; k < 3; k++) begin
      wait_rise(20, w, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL steady_timeout: no request within 20 cycles"); end
      else if (w !== 7) begin errors++; $display("FAIL steady_period: got %0d want 7", w); end
      last += w;
    end
  endtask

  task automatic test_urgent();
    do_reset();
    enable = 1'b1;
    for (int k = 1; k <= 24; k++) begin
      tick(1);
      checks++; if (ref_req !== 1'b0) begin errors++; $display("FAIL urgent_early_req e%0d: got %b want 0", k, ref_req); end
      if (k == 23) begin
        checks++; if (ref_urgent !== 1'b0) begin errors++; $display("FAIL urgent_e23: got %b want 0", ref_urgent); end
      end
    end
    checks++; if (debt !== 4'd6) begin errors++; $display("FAIL urgent_debt: got %0d want 6", debt); end
    checks++; if (ref_urgent !== 1'b1) begin errors++; $display("FAIL urgent_flag: got %b want 1", ref_urgent); end
    tick(1);
    checks++; if (ref_req !== 1'b1) begin errors++; $display("FAIL urgent_req: got %b want 1", ref_req); end
    tick(15);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL urgent_ovf: got %b want 0", overflow); end
  endtask

  task automatic test_overflow();
    do_reset();
    resp_hold = 1'b1;
    enable = 1'b1;
    tick(35);
    checks++; if (debt !== 4'd8) begin errors++; $display("FAIL sat_debt: got %0d want 8", debt); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b want 0", overflow); end
    tick(1);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b want 1", overflow); end
    checks++; if (debt !== 4'd8) begin errors++; $display("FAIL ovf_debt: got %0d want 8", debt); end
    enable = 1'b0;
    idle_hint = 1'b1;
    resp_hold = 1'b0;
    tick(10);
    checks++; if (debt !== 4'd0) begin errors++; $display("FAIL drain_debt: got %0d want 0", debt); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b want 1", overflow); end
  endtask

  task automatic test_coincide();
    do_reset();
    enable = 1'b1;
    tick(7);
    idle_hint = 1'b1;
    tick(3);
    checks++; if (ref_req !== 1'b1) begin errors++; $display("FAIL coin_req_e10: got %b want 1", ref_req); end
    checks++; if (debt !== 4'd2) begin errors++; $display("FAIL coin_debt_e10: got %0d want 2", debt); end
    tick(5);
    checks++; if (debt !== 4'd3) begin errors++; $display("FAIL coin_debt_e15: got %0d want 3", debt); end
    tick(1);
    checks++; if (debt !== 4'd3) begin errors++; $display("FAIL coin_debt_e16: got %0d want 3", debt); end
  endtask

  task automatic test_ranks();
    int w;
    bit ok;
    do_reset();
    idle_hint = 1'b1;
    tick(3);
    enable = 1'b1;
    for (int r = 0; r < 4; r++) begin
      wait_rise(40, w, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL rank_timeout: request %0d missing", r); end
      else if (ref_rank !== 2'(STAGGER ? r % RANKS : 0) || ref_all !== !STAGGER) begin
        errors++;
        $display("FAIL rank_seq %0d: rank %0d all %b want rank %0d all %b",
                 r, ref_rank, ref_all, STAGGER ? r % RANKS : 0, !STAGGER);
      end
    end
  endtask

  task automatic test_reset_in_req();
    do_reset();
    idle_hint = 1'b1;
    resp_hold = 1'b1;
    tick(3);
    enable = 1'b1;
    tick(5);
    checks++; if (ref_req !== 1'b1) begin errors++; $display("FAIL rst_pre_req: got %b want 1", ref_req); end
    RESET_n = 1'b0;
    #1;
    checks++; if (ref_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", ref_req); end
    checks++; if (debt !== 4'd0) begin errors++; $display("FAIL rst_debt: got %0d want 0", debt); end
    tick(1);
    RESET_n = 1'b1;
    tick(4);
    checks++; if (ref_req !== 1'b0) begin errors++; $display("FAIL rst_idle_req: got %b want 0", ref_req); end
    checks++; if (debt !== 4'd1) begin errors++; $display("FAIL rst_recredit: got %0d want 1", debt); end
    tick(1);
    checks++; if (ref_req !== 1'b1) begin errors++; $display("FAIL rst_rerequest: got %b want 1", ref_req); end
  endtask

  task automatic test_enable_drop();
    do_reset();
    idle_hint = 1'b1;
    tick(3);
    enable = 1'b1;
    tick(5);
    checks++; if (ref_req !== 1'b1) begin errors++; $display("FAIL en_req: got %b want 1", ref_req); end
    enable = 1'b0;
    tick(5);
    checks++; if (debt !== 4'd1) begin errors++; $display("FAIL en_hold_debt: got %0d want 1", debt); end
    tick(1);
    checks++; if (debt !== 4'd0) begin errors++; $display("FAIL en_clear_debt: got %0d want 0", debt); end
    for (int k = 0; k < 20; k++) begin
      tick(1);
      checks++; if (ref_req !== 1'b0) begin errors++; $display("FAIL en_no_req %0d: got %b want 0", k, ref_req); end
    end
  endtask

  task automatic test_random();
    do_reset();
    resp_rand = 1'b1;
    enable = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      tick(1);
      checks++;
      if (ref_req !== m_req) begin
        errors++;
        if (errors < 20) $display("FAIL rand_req cyc %0d: got %b want %b", k, ref_req, m_req);
      end
      checks++;
      if (debt !== 4'(m_debt)) begin
        errors++;
        if (errors < 20) $display("FAIL rand_debt cyc %0d: got %0d want %0d", k, debt, m_debt);
      end
      checks++;
      if (ref_urgent !== (m_debt >= URGENT)) begin
        errors++;
        if (errors < 20) $display("FAIL rand_urgent cyc %0d: got %b want %b", k, ref_urgent, m_debt >= URGENT);
      end
      checks++;
      if (overflow !== m_ovf) begin
        errors++;
        if (errors < 20) $display("FAIL rand_ovf cyc %0d: got %b want %b", k, overflow, m_ovf);
      end
      idle_hint = ($urandom_range(0, 99) < 45);
      if ($urandom_range(0, 199) == 0) enable = ~enable;
    end
  endtask

  initial begin
    RESET_n   = 1'b0;
    enable    = 1'b0;
    idle_hint = 1'b0;
    test_reset();
    test_first_credit();
    test_urgent();
    test_overflow();
    test_coincide();
    test_ranks();
    test_reset_in_req();
    test_enable_drop();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
